exc_ctrl: RTL and testbench

- Exception request controller that sits directly upstream of the datapath.
- Collects raw exception sources (invalid opcode flagged by the decoder, external interrupt line) and latches them as pending.
- Drives the datapath's Exc/EStatus inputs under a hold-until-acknowledge handshake, consuming the datapath's ExcAck.
- Tracks handler residency until ERet; masks new exceptions while a handler runs and reports double faults.

---
 rtl/exc_ctrl_if.sv | 25 ++
 rtl/exc_ctrl.sv | 121 ++++++++++++
 tb/tb_exc_ctrl.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/exc_ctrl_if.sv
// Bundle between the exception controller and the datapath/decoder side.
// Exc is the valid and ExcAck the ready: once Exc rises, Exc and EStatus stay frozen until ExcAck is sampled high.
interface exc_ctrl_if #(
  parameter int CNT_W = 8
);
  logic             invalid_op;
  logic             ext_irq;
  logic             ExcAck;
  logic             ERet;
  logic             Exc;
  logic [3:0]       EStatus;
  logic             in_handler;
  logic             double_fault;
  logic [CNT_W-1:0] lost_irq_cnt;

  modport master (
    output invalid_op, ext_irq, ExcAck, ERet,
    input  Exc, EStatus, in_handler, double_fault, lost_irq_cnt
  );

  modport slave (
    input  invalid_op, ext_irq, ExcAck, ERet,
    output Exc, EStatus, in_handler, double_fault, lost_irq_cnt
  );
endinterface

// File: rtl/exc_ctrl.sv
// Exception request controller: latches invalid-opcode and external IRQ causes,
// requests the datapath with a hold-until-ack handshake and tracks handler residency.
module exc_ctrl #(
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = 8
) (
  input  logic       clk,
  input  logic       reset,
  exc_ctrl_if.slave  bus,
  output logic [1:0] dbg_state_o
);
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    HANDLER = 2'd2
  } state_e;

  localparam logic [3:0]       CAUSE_NONE = 4'b0000;
  localparam logic [3:0]       CAUSE_INV  = 4'b0001;
  localparam logic [3:0]       CAUSE_IRQ  = 4'b0010;
  localparam logic [CNT_W-1:0] CNT_MAX    = '1;
  localparam logic [CNT_W-1:0] CNT_ONE    = {{(CNT_W-1){1'b0}}, 1'b1};

  state_e                 state_q;
  logic [SYNC_STAGES-1:0] sync_q;
  logic [SYNC_STAGES-1:0] sync_vld_q;
  logic                   prev_q;
  logic                   prev_vld_q;
  logic                   pend_inv_q, pend_inv_d;
  logic                   pend_irq_q, pend_irq_d;
  logic                   exc_q;
  logic [3:0]             estatus_q;
  logic                   in_handler_q;
  logic                   double_fault_q;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   irq_edge;
  logic                   irq_drop;
  logic                   ack_take;

  // An edge only counts when both samples compared are real post-reset samples,
  // so a level held high through reset is never mistaken for a fresh interrupt.
  always_comb begin
    irq_edge   = sync_q[SYNC_STAGES-1] & sync_vld_q[SYNC_STAGES-1] & ~prev_q & prev_vld_q;
    irq_drop   = irq_edge & (pend_irq_q | (state_q == HANDLER));
    ack_take   = (state_q == REQ) & bus.ExcAck;
    pend_inv_d = (pend_inv_q & ~(ack_take & (estatus_q == CAUSE_INV)))
               | (bus.invalid_op & (state_q != HANDLER));
    pend_irq_d = (pend_irq_q & ~(ack_take & (estatus_q == CAUSE_IRQ)))
               | (irq_edge & ~irq_drop);
    cnt_d      = cnt_q;
    if (irq_drop && (cnt_q != CNT_MAX)) cnt_d = cnt_q + CNT_ONE;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_q     <= '0;
      sync_vld_q <= '0;
      prev_q     <= 1'b0;
      prev_vld_q <= 1'b0;
    end else begin
      sync_q     <= {sync_q[SYNC_STAGES-2:0], bus.ext_irq};
      sync_vld_q <= {sync_vld_q[SYNC_STAGES-2:0], 1'b1};
      prev_q     <= sync_q[SYNC_STAGES-1];
      prev_vld_q <= sync_vld_q[SYNC_STAGES-1];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q        <= IDLE;
      exc_q          <= 1'b0;
      estatus_q      <= CAUSE_NONE;
      in_handler_q   <= 1'b0;
      double_fault_q <= 1'b0;
      pend_inv_q     <= 1'b0;
      pend_irq_q     <= 1'b0;
      cnt_q          <= '0;
    end else begin
      pend_inv_q <= pend_inv_d;
      pend_irq_q <= pend_irq_d;
      cnt_q      <= cnt_d;
      case (state_q)
        IDLE: begin
          if (pend_inv_q || pend_irq_q) begin
            state_q   <= REQ;
            exc_q     <= 1'b1;
            estatus_q <= pend_inv_q ? CAUSE_INV : CAUSE_IRQ;
          end
        end
        REQ: begin
          if (bus.ExcAck) begin
            state_q      <= HANDLER;
            exc_q        <= 1'b0;
            in_handler_q <= 1'b1;
          end
        end
        HANDLER: begin
          if (bus.invalid_op) double_fault_q <= 1'b1;
          if (bus.ERet) begin
            state_q      <= IDLE;
            in_handler_q <= 1'b0;
            estatus_q    <= CAUSE_NONE;
          end
        end
        default: begin
          state_q      <= IDLE;
          exc_q        <= 1'b0;
          estatus_q    <= CAUSE_NONE;
          in_handler_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.Exc          = exc_q;
  assign bus.EStatus      = estatus_q;
  assign bus.in_handler   = in_handler_q;
  assign bus.double_fault = double_fault_q;
  assign bus.lost_irq_cnt = cnt_q;
  assign dbg_state_o      = state_q;
endmodule

// File: tb/tb_exc_ctrl.sv
// Bench for exc_ctrl: per-cycle vector table through an expected-value queue,
// plus hand-written sequences for async reset and counter saturation.
module tb_exc_ctrl;
  localparam int SYNC_STAGES = 2;
  localparam int CNT_W       = 2;
  localparam int W           = 9;

  typedef struct {
    logic         inv;
    logic         irq;
    logic         ack;
    logic         eret;
    logic [W-1:0] exp;
  } vec_t;

  logic         clk;
  logic         reset;
  logic [1:0]   dbg_state;
  logic [W-1:0] exp_q[$];
  vec_t         tbl[$];
  int           n_checks;
  int           n_errors;

  exc_ctrl_if #(.CNT_W(CNT_W)) bus ();

  exc_ctrl #(.SYNC_STAGES(SYNC_STAGES), .CNT_W(CNT_W)) dut (
    .clk         (clk),
    .reset       (reset),
    .bus         (bus),
    .dbg_state_o (dbg_state)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [W-1:0] ex(input logic e, input logic [3:0] es, input logic ih,
                                      input logic df, input logic [1:0] cnt);
    return {e, es, ih, df, cnt};
  endfunction

  function automatic logic [W-1:0] actual();
    return {bus.Exc, bus.EStatus, bus.in_handler, bus.double_fault, bus.lost_irq_cnt};
  endfunction

  function automatic void add(input logic inv, input logic irq, input logic ack, input logic eret,
                              input logic [W-1:0] exp);
    vec_t v;
    v.inv = inv; v.irq = irq; v.ack = ack; v.eret = eret; v.exp = exp;
    tbl.push_back(v);
  endfunction

  task automatic check(input string name, input logic [W-1:0] exp);
    logic [W-1:0] act;
    act = actual();
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got {exc,estatus,in_h,dfault,cnt}=%b expected %b", name, act, exp);
    end
  endtask

  task automatic check_state(input string name, input logic [1:0] exp);
    n_checks++;
    if (dbg_state !== exp) begin
      n_errors++;
      $display("FAIL %s: got state=%0d expected %0d", name, dbg_state, exp);
    end
  endtask

  task automatic drive(input logic inv, input logic irq, input logic ack, input logic eret);
    bus.invalid_op = inv;
    bus.ext_irq    = irq;
    bus.ExcAck     = ack;
    bus.ERet       = eret;
  endtask

  // driver: apply one cycle of inputs, queue what the outputs must be after the edge
  task automatic step(input string name, input logic inv, input logic irq, input logic ack,
                      input logic eret, input logic [W-1:0] exp);
    drive(inv, irq, ack, eret);
    exp_q.push_back(exp);
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL %s: expected queue empty", name);
    end else begin
      check(name, exp_q.pop_front());
    end
  endtask

  task automatic tick(input logic inv, input logic irq, input logic ack, input logic eret);
    drive(inv, irq, ack, eret);
    @(posedge clk);
    #1;
  endtask

  task automatic irq_pulse();
    tick(0, 1, 0, 0);
    tick(0, 1, 0, 0);
    tick(0, 0, 0, 0);
    tick(0, 0, 0, 0);
  endtask

  initial begin
    logic [W-1:0] z;
    n_checks = 0;
    n_errors = 0;
    z = '0;

    // reset held with both sources active
    reset = 1'b0;
    drive(1, 1, 0, 0);
    #1;
    check("rst_t0", z);
    check_state("rst_state", 2'd0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      check($sformatf("rst_hold%0d", i), z);
    end
    reset = 1'b1;

    // ext_irq held high across release: not a fresh edge
    for (int i = 0; i < 6; i++) add(0, 1, 0, 0, z);
    for (int i = 0; i < 4; i++) add(0, 0, 0, 0, z);
    // invalid-op handshake, ignored ERet in REQ / ExcAck in HANDLER / both in IDLE
    add(1, 0, 0, 0, z);
    add(0, 0, 0, 0, ex(1, 4'b0001, 0, 0, 0));
    add(0, 0, 0, 0, ex(1, 4'b0001, 0, 0, 0));
    add(0, 0, 0, 1, ex(1, 4'b0001, 0, 0, 0));
    for (int i = 0; i < 3; i++) add(0, 0, 0, 0, ex(1, 4'b0001, 0, 0, 0));
    add(0, 0, 1, 0, ex(0, 4'b0001, 1, 0, 0));
    add(0, 0, 0, 0, ex(0, 4'b0001, 1, 0, 0));
    add(0, 0, 1, 0, ex(0, 4'b0001, 1, 0, 0));
    add(0, 0, 0, 0, ex(0, 4'b0001, 1, 0, 0));
    add(0, 0, 0, 1, z);
    add(0, 0, 1, 0, z);
    add(0, 0, 0, 1, z);
    // IRQ latency: rise sampled at edge 1, Exc after edge 4
    add(0, 1, 0, 0, z);
    add(0, 1, 0, 0, z);
    add(0, 1, 0, 0, z);
    add(0, 1, 0, 0, ex(1, 4'b0010, 0, 0, 0));
    add(0, 1, 1, 0, ex(0, 4'b0010, 1, 0, 0));
    add(0, 0, 0, 1, z);
    add(0, 0, 0, 0, z);
    add(0, 0, 0, 0, z);
    // simultaneous invalid_op and IRQ edge: inv first, irq two edges after ERet
    add(0, 1, 0, 0, z);
    add(0, 1, 0, 0, z);
    add(1, 1, 0, 0, z);
    add(0, 1, 0, 0, ex(1, 4'b0001, 0, 0, 0));
    add(0, 1, 1, 0, ex(0, 4'b0001, 1, 0, 0));
    add(0, 1, 0, 1, z);
    add(0, 1, 0, 0, ex(1, 4'b0010, 0, 0, 0));
    add(0, 1, 1, 0, ex(0, 4'b0010, 1, 0, 0));
    add(0, 0, 0, 1, z);
    add(0, 0, 0, 0, z);
    // masking: three IRQ edges and an invalid_op inside the handler
    add(1, 0, 0, 0, z);
    add(0, 0, 0, 0, ex(1, 4'b0001, 0, 0, 0));
    add(0, 0, 1, 0, ex(0, 4'b0001, 1, 0, 0));
    add(0, 1, 0, 0, ex(0, 4'b0001, 1, 0, 0));
    add(0, 1, 0, 0, ex(0, 4'b0001, 1, 0, 0));
    add(0, 0, 0, 0, ex(0, 4'b0001, 1, 0, 1));
    add(1, 0, 0, 0, ex(0, 4'b0001, 1, 1, 1));
    add(0, 1, 0, 0, ex(0, 4'b0001, 1, 1, 1));
    add(0, 1, 0, 0, ex(0, 4'b0001, 1, 1, 1));
    add(0, 0, 0, 0, ex(0, 4'b0001, 1, 1, 2));
    add(0, 0, 0, 0, ex(0, 4'b0001, 1, 1, 2));
    add(0, 1, 0, 0, ex(0, 4'b0001, 1, 1, 2));
    add(0, 1, 0, 0, ex(0, 4'b0001, 1, 1, 2));
    add(0, 0, 0, 0, ex(0, 4'b0001, 1, 1, 3));
    add(0, 0, 0, 0, ex(0, 4'b0001, 1, 1, 3));
    add(0, 0, 0, 1, ex(0, 4'b0000, 0, 1, 3));
    add(0, 0, 0, 0, ex(0, 4'b0000, 0, 1, 3));
    add(0, 0, 0, 0, ex(0, 4'b0000, 0, 1, 3));

    foreach (tbl[i]) begin
      step($sformatf("tbl[%0d]", i), tbl[i].inv, tbl[i].irq, tbl[i].ack, tbl[i].eret, tbl[i].exp);
    end

    // async reset mid-cycle clears double_fault and counter
    #2 reset = 1'b0;
    #1;
    check("rst_async", z);
    @(posedge clk);
    #1;
    reset = 1'b1;
    for (int i = 0; i < 4; i++) tick(0, 0, 0, 0);
    step("sat_idle", 0, 0, 0, 0, z);

    // saturation: five dropped edges with a 2-bit counter
    step("sat_inv", 1, 0, 0, 0, z);
    step("sat_req", 0, 0, 0, 0, ex(1, 4'b0001, 0, 0, 0));
    step("sat_ack", 0, 0, 1, 0, ex(0, 4'b0001, 1, 0, 0));
    for (int i = 0; i < 3; i++) irq_pulse();
    step("sat_cnt3", 0, 0, 0, 0, ex(0, 4'b0001, 1, 0, 3));
    for (int i = 0; i < 2; i++) irq_pulse();
    step("sat_cnt5", 0, 0, 0, 0, ex(0, 4'b0001, 1, 0, 3));
    step("sat_eret", 0, 0, 0, 1, ex(0, 4'b0000, 0, 0, 3));
    step("sat_quiet", 0, 0, 0, 0, ex(0, 4'b0000, 0, 0, 3));

    // async reset while in REQ: outputs drop within the cycle, pending lost
    step("mreq_inv", 1, 0, 0, 0, ex(0, 4'b0000, 0, 0, 3));
    step("mreq_req", 0, 0, 0, 0, ex(1, 4'b0001, 0, 0, 3));
    drive(1, 1, 0, 0);
    #2 reset = 1'b0;
    #1;
    check("mreq_rst", z);
    check_state("mreq_state", 2'd0);
    @(posedge clk);
    #1;
    check("mreq_hold", z);
    drive(0, 0, 0, 0);
    reset = 1'b1;
    for (int i = 0; i < 4; i++) step($sformatf("post_rst%0d", i), 0, 0, 0, 0, z);

    n_checks++;
    if (exp_q.size() != 0) begin
      n_errors++;
      $display("FAIL exp_q_drain: got %0d entries left expected 0", exp_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
